// File: rtl/dmem_arbiter_ctrl_pkg.sv
// Shared constants for the data-memory arbiter/controller.
// Access sizes, requester ids, FSM states, alignment helper.
package dmem_arbiter_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int REQ_CORE   = 0;
    localparam int REQ_LOADER = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WR,
        RESP
    } state_e;

    // Misaligned half/word or the reserved size encoding.
    function automatic logic req_bad(input logic [1:0] size,
                                     input logic [1:0] lane);
        logic bad;
        unique case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_ctrl_if.sv
// Requester-side bundle of the data-memory arbiter.
// Two requesters share each vector, requester i owns slice i.
interface dmem_arbiter_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_we;
    logic [3:0]              req_size;
    logic [1:0]              req_unsigned;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [63:0]             req_wdata;
    logic [1:0]              rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 sub-word accesses.
// Load extract + extension, and store byte merge into a word.
module dmem_lane_align
    import dmem_arbiter_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the addressed lane(s), extend loads, splice stores.
    always_comb begin
        b          = word[{lane, 3'b000} +: 8];
        h          = word[{lane[1], 4'b0000} +: 16];
        load_data  = word;
        merge_data = wdata;
        unique case (size)
            SIZE_B: begin
                load_data  = {{24{b[7] & ~uns}}, b};
                merge_data = word;
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data  = {{16{h[15] & ~uns}}, h};
                merge_data = word;
                merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Round-robin arbiter and access sequencer for the data memory.
// One transaction in flight; sub-word stores use read-modify-write.
module dmem_arbiter_ctrl
    import dmem_arbiter_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_ctrl_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    state_e                  state;
    logic                    last_grant;
    logic [NREQ-1:0]         grant;
    logic                    gid;
    logic                    bad;
    logic                    sel_we;
    logic                    sel_uns;
    logic [1:0]              sel_size;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    logic                    id;
    logic                    we;
    logic                    uns;
    logic [1:0]              size;
    logic [1:0]              lane;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    logic [1:0]              rsp_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   maddr;
    logic [DATA_WIDTH-1:0]   mwd;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   merge_data;

    // Grant only in IDLE; on a tie favour the requester not served last.
    always_comb begin
        grant = '0;
        if (state == IDLE && !reset) begin
            unique case (1'b1)
                (bus.req_valid == 2'b11):
                    grant[last_grant ? REQ_CORE : REQ_LOADER] = 1'b1;
                (bus.req_valid[REQ_CORE] && !bus.req_valid[REQ_LOADER]):
                    grant[REQ_CORE] = 1'b1;
                (bus.req_valid[REQ_LOADER] && !bus.req_valid[REQ_CORE]):
                    grant[REQ_LOADER] = 1'b1;
                default: ;
            endcase
        end
    end

    // Mux the granted requester's fields for latching.
    always_comb begin
        gid       = grant[REQ_LOADER];
        sel_we    = bus.req_we[gid];
        sel_uns   = bus.req_unsigned[gid];
        sel_size  = gid ? bus.req_size[3:2] : bus.req_size[1:0];
        sel_addr  = gid ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : bus.req_addr[ADDR_WIDTH-1:0];
        sel_wdata = gid ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        bad       = req_bad(sel_size, sel_addr[1:0]);
    end

    dmem_lane_align u_align (
        .size       (size),
        .uns        (uns),
        .lane       (lane),
        .word       (mem_rd),
        .wdata      (wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            we         <= 1'b0;
            uns        <= 1'b0;
            size       <= SIZE_B;
            lane       <= 2'b00;
            wdata      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            rsp_q      <= 2'b00;
            we_q       <= 1'b0;
            maddr      <= '0;
            mwd        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    rsp_q <= 2'b00;
                    we_q  <= 1'b0;
                    if (|grant) begin
                        last_grant <= gid;
                        id         <= gid;
                        we         <= sel_we;
                        uns        <= sel_uns;
                        size       <= sel_size;
                        lane       <= sel_addr[1:0];
                        wdata      <= sel_wdata;
                        rdata      <= '0;
                        err        <= bad;
                        if (bad) begin
                            rsp_q <= gid ? 2'b10 : 2'b01;
                            state <= RESP;
                        end else begin
                            maddr <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                            state <= ACCESS;
                            if (sel_we && sel_size == SIZE_W) begin
                                we_q <= 1'b1;
                                mwd  <= sel_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    we_q <= 1'b0;
                    if (we && size != SIZE_W) begin
                        mwd   <= merge_data;
                        we_q  <= 1'b1;
                        state <= MERGE_WR;
                    end else begin
                        if (!we) rdata <= load_data;
                        rsp_q <= id ? 2'b10 : 2'b01;
                        state <= RESP;
                    end
                end
                MERGE_WR: begin
                    we_q  <= 1'b0;
                    rsp_q <= id ? 2'b10 : 2'b01;
                    state <= RESP;
                end
                RESP: begin
                    rsp_q <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset cycle suppresses any pending write or response.
    assign mem_we        = we_q & ~reset;
    assign mem_addr      = maddr;
    assign mem_wd        = mwd;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_q & {2{~reset}};
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;

endmodule
